// File: rtl/lcd_sequencer_if.sv
// rtl/lcd_sequencer_if.sv - CPU-side push/status bundle for the LCD sequencer
interface lcd_sequencer_if;
  logic [7:0] wr_data;
  logic       wr_rs;
  logic       wr_stb;
  logic       clr_timeout;
  logic       full;
  logic       busy;
  logic       timeout;

  modport master (
    output wr_data, wr_rs, wr_stb, clr_timeout,
    input  full, busy, timeout
  );

  modport slave (
    input  wr_data, wr_rs, wr_stb, clr_timeout,
    output full, busy, timeout
  );
endinterface

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - FIFO-buffered HD44780 write sequencer with timed enable pulses
// Define LCD_BUSY_POLL_EN to poll the busy flag before each write; otherwise a fixed DELAY_CYCLES wait follows it.
module lcd_sequencer #(
  parameter int FIFO_AW        = 2,
  parameter int SETUP_CYCLES   = 1,
  parameter int EN_HIGH_CYCLES = 4,
  parameter int POLL_LIMIT     = 255,
  parameter int DELAY_CYCLES   = 64
) (
  input  logic           clk,
  input  logic           reset,
  lcd_sequencer_if.slave cpu,
  inout  wire  [7:0]     io_bus,
  output logic           lcd_en,
  output logic           lcd_rnw,
  output logic           lcd_rs
);
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int MAX_PH = (SETUP_CYCLES > EN_HIGH_CYCLES) ? SETUP_CYCLES : EN_HIGH_CYCLES;
  localparam int MAX_LD = (POLL_LIMIT > DELAY_CYCLES) ? POLL_LIMIT : DELAY_CYCLES;
  // One width covers phase timing, the post-write wait and the poll count.
  localparam int CW     = $clog2(((MAX_PH > MAX_LD) ? MAX_PH : MAX_LD) + 1);

  typedef enum logic [2:0] {
    IDLE,
`ifdef LCD_BUSY_POLL_EN
    POLL_SETUP,
    POLL_EN,
    POLL_GAP,
`else
    WAIT,
`endif
    WR_SETUP,
    WR_EN,
    WR_HOLD
  } state_t;

  state_t             state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]   count;
  logic [8:0]         head;
  logic               push, pop, drive;

  assign push     = cpu.wr_stb && (count < (FIFO_AW+1)'(DEPTH));
  assign pop      = (state == WR_HOLD);
  assign head     = mem[rp];
  assign cpu.full = (count == (FIFO_AW+1)'(DEPTH));
  assign cpu.busy = (count != '0) || (state != IDLE);
  assign io_bus   = drive ? head[7:0] : 8'hzz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {cpu.wr_rs, cpu.wr_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

`ifdef LCD_BUSY_POLL_EN
  logic [CW-1:0] poll_cnt, poll_d;
  logic          bf, bf_d, timeout_q, timeout_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt  <= '0;
      bf        <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      poll_cnt  <= poll_d;
      bf        <= bf_d;
      timeout_q <= timeout_set | (timeout_q & ~cpu.clr_timeout);
    end
  end

  assign cpu.timeout = timeout_q;
`else
  assign cpu.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    drive   = 1'b0;
    lcd_en  = 1'b0;
    lcd_rnw = 1'b1;
    lcd_rs  = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    poll_d      = poll_cnt;
    bf_d        = bf;
    timeout_set = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (count != '0) begin
`ifdef LCD_BUSY_POLL_EN
          state_d = POLL_SETUP;
          poll_d  = '0;
`else
          state_d = WR_SETUP;
`endif
        end
      end
`ifdef LCD_BUSY_POLL_EN
      POLL_SETUP: begin
        if (cnt == CW'(SETUP_CYCLES - 1)) begin
          state_d = POLL_EN;
          cnt_d   = '0;
        end
      end
      POLL_EN: begin
        lcd_en = 1'b1;
        if (cnt == CW'(EN_HIGH_CYCLES - 1)) begin
          bf_d    = io_bus[7];
          state_d = POLL_GAP;
          cnt_d   = '0;
        end
      end
      POLL_GAP: begin
        cnt_d  = '0;
        poll_d = poll_cnt + 1'b1;
        // A still-busy LCD after POLL_LIMIT polls is written anyway and flagged.
        if (bf && (poll_d < CW'(POLL_LIMIT))) begin
          state_d = POLL_SETUP;
        end else begin
          state_d     = WR_SETUP;
          timeout_set = bf;
        end
      end
`else
      WAIT: begin
        if (cnt == CW'(DELAY_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      WR_SETUP: begin
        lcd_rnw = 1'b0;
        lcd_rs  = head[8];
        drive   = 1'b1;
        if (cnt == CW'(SETUP_CYCLES - 1)) begin
          state_d = WR_EN;
          cnt_d   = '0;
        end
      end
      WR_EN: begin
        lcd_en  = 1'b1;
        lcd_rnw = 1'b0;
        lcd_rs  = head[8];
        drive   = 1'b1;
        if (cnt == CW'(EN_HIGH_CYCLES - 1)) begin
          state_d = WR_HOLD;
          cnt_d   = '0;
        end
      end
      WR_HOLD: begin
        lcd_rnw = 1'b0;
        lcd_rs  = head[8];
        drive   = 1'b1;
        cnt_d   = '0;
`ifdef LCD_BUSY_POLL_EN
        state_d = IDLE;
`else
        state_d = WAIT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
